// File: rtl/icache_fill_ctrl.sv
// Direct-mapped instruction cache with a single-outstanding miss/fill controller.
// Vectors are MSB-high: bit 31 here is bit 0 of the big-endian numbering, so pc[31:7] is the line address.
module icache_fill_ctrl #(
    parameter int unsigned INDEX_BITS = 2,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_req,
    input  logic [31:0]           pc,
    input  logic                  flush,
    input  logic                  mem_valid,
    input  logic [31:0][31:0]     mem_instr32,
    output logic                  miss,
    output logic [31:0]           missedPC,
    output logic [31:0]           instr,
    output logic                  instr_valid,
    output logic                  stall,
    output logic [15:0]           miss_count
);
    localparam int unsigned LINES  = 1 << INDEX_BITS;
    localparam int unsigned WORDS  = 32;
    localparam int unsigned LINE_W = 25;
    localparam int unsigned TAG_W  = LINE_W - INDEX_BITS;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [LINES-1:0]       valid_q, valid_d;
    logic [31:0]            missed_pc_q, missed_pc_d;
    logic [15:0]            miss_cnt_q, miss_cnt_d;
    logic [CNT_W-1:0]       tmo_q, tmo_d;
    logic                   miss_q, miss_d;
    logic [TAG_W-1:0]       tag_q  [LINES];
    logic [WORDS-1:0][31:0] data_q [LINES];

    logic [INDEX_BITS-1:0]  idx_c;
    logic [INDEX_BITS-1:0]  fill_idx_c;
    logic [TAG_W-1:0]       tag_c;
    logic [4:0]             word_c;
    logic                   hit_c;
    logic                   fill_we_c;
    logic                   unused_byte_c;

    // Address split and combinational lookup
    assign idx_c         = pc[7 +: INDEX_BITS];
    assign tag_c         = pc[31 -: TAG_W];
    assign word_c        = pc[6:2];
    assign unused_byte_c = ^pc[1:0];
    assign fill_idx_c    = missed_pc_q[7 +: INDEX_BITS];
    assign hit_c         = valid_q[idx_c] && (tag_q[idx_c] == tag_c);

    assign instr       = data_q[idx_c][word_c];
    assign instr_valid = fetch_req && hit_c && (state_q == IDLE) && !flush;
    assign stall       = fetch_req && !instr_valid;
    assign miss        = miss_q;
    assign missedPC    = missed_pc_q;
    assign miss_count  = miss_cnt_q;

    // Next-state logic; flush clears valid bits in every state, a same-cycle fill re-sets its own line
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        missed_pc_d = missed_pc_q;
        miss_cnt_d  = miss_cnt_q;
        tmo_d       = tmo_q;
        miss_d      = 1'b0;
        fill_we_c   = 1'b0;
        if (flush) begin
            valid_d = '0;
        end
        unique case (state_q)
            IDLE: begin
                if (!flush && fetch_req && !hit_c) begin
                    missed_pc_d = {pc[31:7], 7'b0};
                    if (miss_cnt_q != 16'hFFFF) begin
                        miss_cnt_d = miss_cnt_q + 16'd1;
                    end
                    miss_d  = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                tmo_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (mem_valid) begin
                    fill_we_c           = 1'b1;
                    valid_d[fill_idx_c] = 1'b1;
                    state_d             = IDLE;
                end else if (tmo_q == CNT_W'(TIMEOUT - 1)) begin
                    miss_d  = 1'b1;
                    state_d = REQ;
                end else begin
                    tmo_d = tmo_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            missed_pc_q <= '0;
            miss_cnt_q  <= '0;
            tmo_q       <= '0;
            miss_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            missed_pc_q <= missed_pc_d;
            miss_cnt_q  <= miss_cnt_d;
            tmo_q       <= tmo_d;
            miss_q      <= miss_d;
        end
    end

    // Tag/data arrays carry no reset; the valid bits gate them
    always_ff @(posedge clk) begin
        if (fill_we_c) begin
            tag_q[fill_idx_c]  <= missed_pc_q[31 -: TAG_W];
            data_q[fill_idx_c] <= mem_instr32;
        end
    end

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Bench for icache_fill_ctrl: directed scenarios plus random traffic against a line-level cache model.
module tb_icache_fill_ctrl;
    localparam int TMO = 15;

    logic              clk;
    logic              reset;
    logic              fetch_req;
    logic [31:0]       pc;
    logic              flush;
    logic              mem_valid;
    logic [31:0][31:0] mem_instr32;
    logic              miss;
    logic [31:0]       missedPC;
    logic [31:0]       instr;
    logic              instr_valid;
    logic              stall;
    logic [15:0]       miss_count;

    icache_fill_ctrl #(.INDEX_BITS(2), .TIMEOUT(TMO)) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_req   (fetch_req),
        .pc          (pc),
        .flush       (flush),
        .mem_valid   (mem_valid),
        .mem_instr32 (mem_instr32),
        .miss        (miss),
        .missedPC    (missedPC),
        .instr       (instr),
        .instr_valid (instr_valid),
        .stall       (stall),
        .miss_count  (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: which line address each index holds, plus the fill in flight measured in cycles since its last pulse
    logic [24:0] m_line [4];
    logic [31:0] m_data [4][32];
    logic [3:0]  m_present;
    bit          m_busy;
    int          m_since;
    logic [31:0] m_mpc;
    logic [15:0] m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_hit(input logic [31:0] a);
        logic [1:0] ix;
        ix = a[8:7];
        return m_present[ix] && (m_line[ix] == a[31:7]);
    endfunction

    task automatic m_reset();
        m_present = '0;
        m_busy    = 1'b0;
        m_since   = 0;
        m_mpc     = '0;
        m_cnt     = '0;
    endtask

    always @(posedge clk) begin
        bit         launch;
        bit         fill;
        logic [1:0] fix;
        if (!reset) begin
            m_reset();
        end else begin
            launch = !m_busy && fetch_req && !flush && !m_hit(pc);
            fill   = m_busy && (m_since != 0) && mem_valid;
            fix    = m_mpc[8:7];
            if (flush) m_present = '0;
            if (fill) begin
                m_line[fix]    = m_mpc[31:7];
                for (int w = 0; w < 32; w++) m_data[fix][w] = mem_instr32[w];
                m_present[fix] = 1'b1;
                m_busy         = 1'b0;
            end else if (m_busy) begin
                m_since = (m_since == TMO) ? 0 : m_since + 1;
            end else if (launch) begin
                m_busy  = 1'b1;
                m_since = 0;
                m_mpc   = {pc[31:7], 7'b0};
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
        end
    end

    // Every-cycle comparison against the model, sampled mid-cycle
    always @(negedge clk) begin
        bit exp_iv;
        if (!reset) begin
            check("rst_miss", 32'(miss), 32'd0);
            check("rst_missedPC", missedPC, 32'd0);
            check("rst_miss_count", 32'(miss_count), 32'd0);
            check("rst_instr_valid", 32'(instr_valid), 32'd0);
            check("rst_stall", 32'(stall), 32'(fetch_req));
        end else begin
            exp_iv = fetch_req && !m_busy && !flush && m_hit(pc);
            check("instr_valid", 32'(instr_valid), 32'(exp_iv));
            check("stall", 32'(stall), 32'(fetch_req && !exp_iv));
            check("miss", 32'(miss), 32'(m_busy && m_since == 0));
            check("missedPC", missedPC, m_mpc);
            check("miss_count", 32'(miss_count), 32'(m_cnt));
            if (exp_iv) check("instr", instr, m_data[pc[8:7]][pc[6:2]]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) mem_instr32[i] = $urandom;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    // Miss on addr, return the line lat cycles after the pulse, then expect a hit
    task automatic fill_miss(input logic [31:0] addr, input int lat);
        logic [31:0] line_addr;
        line_addr = {addr[31:7], 7'b0};
        pc        = addr;
        fetch_req = 1'b1;
        tick();
        check("fill_miss_pulse", 32'(miss), 32'd1);
        check("fill_missedPC", missedPC, line_addr);
        repeat (lat) tick();
        mem_valid = 1'b1;
        tick();
        mem_valid = 1'b0;
        check("fill_hit", 32'(instr_valid), 32'd1);
    endtask

    logic [31:0] lit_w1;
    logic [31:0] pool [8];

    initial begin
        reset     = 1'b0;
        fetch_req = 1'b0;
        pc        = '0;
        flush     = 1'b0;
        mem_valid = 1'b0;
        for (int i = 0; i < 32; i++) mem_instr32[i] = $urandom;
        pool = '{32'h0, 32'h80, 32'h100, 32'h180, 32'h200, 32'h1000, 32'h2100, 32'h3000};
        m_reset();
        repeat (3) tick();
        reset = 1'b1;
        tick();

        // Cold fetch at 0x84
        pc        = 32'h84;
        fetch_req = 1'b1;
        tick();
        check("t1_miss", 32'(miss), 32'd1);
        check("t1_missedPC", missedPC, 32'h80);
        tick();
        check("t1_single_pulse", 32'(miss), 32'd0);
        tick();
        tick();
        mem_valid = 1'b1;
        lit_w1    = mem_instr32[1];
        tick();
        mem_valid = 1'b0;
        check("t1_instr_valid", 32'(instr_valid), 32'd1);
        check("t1_instr", instr, lit_w1);
        check("t1_miss_count", 32'(miss_count), 32'd1);

        // Sequential fetch across the filled line
        for (int a = 32'h80; a <= 32'hFC; a += 4) begin
            pc = 32'(a);
            #1;
            check("t2_hit", 32'(instr_valid), 32'd1);
            check("t2_no_miss", 32'(miss), 32'd0);
            tick();
        end

        // Conflict on index 0
        pulse_reset();
        fill_miss(32'h0, 3);
        fill_miss(32'h200, 3);
        fill_miss(32'h0, 3);
        check("t3_miss_count", 32'(miss_count), 32'd3);

        // Timeout re-issue
        pc = 32'h1000;
        tick();
        check("t4_miss", 32'(miss), 32'd1);
        for (int k = 1; k <= TMO; k++) begin
            tick();
            check("t4_wait_quiet", 32'(miss), 32'd0);
        end
        tick();
        check("t4_reissue", 32'(miss), 32'd1);
        check("t4_count_held", 32'(miss_count), 32'd4);
        tick();
        mem_valid = 1'b1;
        tick();
        mem_valid = 1'b0;
        check("t4_hit", 32'(instr_valid), 32'd1);

        // Flush during a fill; the fill still installs its line
        fill_miss(32'h80, 3);
        pc = 32'h2100;
        tick();
        check("t5_miss", 32'(miss), 32'd1);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        mem_valid = 1'b1;
        tick();
        mem_valid = 1'b0;
        check("t5_fill_survives", 32'(instr_valid), 32'd1);
        pc = 32'h80;
        tick();
        check("t5_flushed_miss", 32'(miss), 32'd1);
        repeat (3) tick();
        mem_valid = 1'b1;
        tick();
        mem_valid = 1'b0;
        flush     = 1'b1;
        #1;
        check("t5_idle_flush_iv", 32'(instr_valid), 32'd0);
        check("t5_idle_flush_stall", 32'(stall), 32'd1);
        tick();
        flush     = 1'b0;
        fetch_req = 1'b0;
        tick();

        // Reset during WAIT
        pc        = 32'h3000;
        fetch_req = 1'b1;
        tick();
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("t6_miss", 32'(miss), 32'd0);
        check("t6_missedPC", missedPC, 32'd0);
        check("t6_miss_count", 32'(miss_count), 32'd0);
        tick();
        reset     = 1'b1;
        fetch_req = 1'b0;
        tick();
        mem_valid = 1'b1;
        tick();
        mem_valid = 1'b0;
        tick();
        pc        = 32'h3000;
        fetch_req = 1'b1;
        #1;
        check("t6_no_stale_hit", 32'(instr_valid), 32'd0);
        tick();
        check("t6_refetch_miss", 32'(miss), 32'd1);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            reset     = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
            fetch_req = ($urandom_range(0, 9) < 8);
            flush     = ($urandom_range(0, 99) < 3);
            mem_valid = ($urandom_range(0, 3) == 0);
            pc        = pool[$urandom_range(0, 7)] | (32'($urandom_range(0, 31)) << 2)
                        | 32'($urandom_range(0, 3));
            tick();
        end
        reset     = 1'b1;
        fetch_req = 1'b0;
        flush     = 1'b0;
        mem_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
